// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and the per-master port state used by the two-master RAM arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    P_IDLE = 2'b00,
    P_PEND = 2'b01,
    P_DATA = 2'b10
  } port_state_e;

endpackage

// File: rtl/ahb_arb_port.sv
// One master-facing port: accepts address phases, buffers a transfer that cannot
// reach the slave yet, and tracks ownership of the slave data phase.
module ahb_arb_port
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              s_hready,
  input  logic              grant,
  output logic              hready,
  output logic              cand,
  output logic              in_data,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_write,
  output logic [2:0]        req_size
);

  port_state_e       state_q, state_d;
  logic              fresh;
  logic              capture;
  logic [ADDR_W-1:0] buf_addr_q;
  logic              buf_write_q;
  logic [2:0]        buf_size_q;
  logic              unused_htrans0;

  // Only HTRANS[1] distinguishes a request; SEQ and NONSEQ are treated alike.
  assign unused_htrans0 = htrans[0];

  always_comb begin
    case (state_q)
      P_PEND:  hready = 1'b0;
      P_DATA:  hready = s_hready;
      default: hready = 1'b1;
    endcase
  end

  assign fresh     = htrans[1] && hready;
  assign cand      = fresh || (state_q == P_PEND);
  assign in_data   = (state_q == P_DATA);
  assign req_addr  = (state_q == P_PEND) ? buf_addr_q  : haddr;
  assign req_write = (state_q == P_PEND) ? buf_write_q : hwrite;
  assign req_size  = (state_q == P_PEND) ? buf_size_q  : hsize;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      P_PEND: if (grant) state_d = P_DATA;
      default: begin
        // Idle, or a data phase the slave has just finished (a stalled one holds).
        if (hready) begin
          if (!fresh) begin
            state_d = P_IDLE;
          end else if (grant) begin
            state_d = P_DATA;
          end else begin
            state_d = P_PEND;
            capture = 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= P_IDLE;
      buf_addr_q  <= '0;
      buf_write_q <= 1'b0;
      buf_size_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        buf_addr_q  <= haddr;
        buf_write_q <= hwrite;
        buf_size_q  <= hsize;
      end
    end
  end

endmodule

// File: rtl/ahb_ram_arbiter.sv
// Two-master to one-slave AHB arbiter: picks one address phase per free slave slot
// (round-robin or M1-priority) and routes data phases to their owning master.
module ahb_ram_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [1:0]        M0_HTRANS,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic [1:0]        M0_HRESP,
  input  logic [1:0]        M1_HTRANS,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic [1:0]        M1_HRESP,
  output logic              S_HSEL,
  output logic [1:0]        S_HTRANS,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [DATA_W-1:0] S_HWDATA,
  input  logic [DATA_W-1:0] S_HRDATA,
  input  logic              S_HREADY
);

  logic [1:0]        cand;
  logic [1:0]        in_data;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] req_addr  [2];
  logic              req_write [2];
  logic [2:0]        req_size  [2];
  logic              last_m1_q;
  logic              slot_free;
  logic              pick_m1;

  ahb_arb_port #(.ADDR_W(ADDR_W)) u_port0 (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .htrans    (M0_HTRANS),
    .haddr     (M0_HADDR),
    .hwrite    (M0_HWRITE),
    .hsize     (M0_HSIZE),
    .s_hready  (S_HREADY),
    .grant     (grant[0]),
    .hready    (M0_HREADY),
    .cand      (cand[0]),
    .in_data   (in_data[0]),
    .req_addr  (req_addr[0]),
    .req_write (req_write[0]),
    .req_size  (req_size[0])
  );

  ahb_arb_port #(.ADDR_W(ADDR_W)) u_port1 (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .htrans    (M1_HTRANS),
    .haddr     (M1_HADDR),
    .hwrite    (M1_HWRITE),
    .hsize     (M1_HSIZE),
    .s_hready  (S_HREADY),
    .grant     (grant[1]),
    .hready    (M1_HREADY),
    .cand      (cand[1]),
    .in_data   (in_data[1]),
    .req_addr  (req_addr[1]),
    .req_write (req_write[1]),
    .req_size  (req_size[1])
  );

  // A stalled data phase blocks the slot; reset blocks it so nothing escapes mid-reset.
  assign slot_free = !HRESET && ((in_data == 2'b00) || S_HREADY);
  assign pick_m1   = (RR_EN == 0) || !last_m1_q;

  always_comb begin
    grant = 2'b00;
    if (slot_free) begin
      if (cand == 2'b11) grant = pick_m1 ? 2'b10 : 2'b01;
      else               grant = cand;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET)     last_m1_q <= 1'b1;
    else if (|grant) last_m1_q <= grant[1];
  end

  assign S_HSEL   = |grant;
  assign S_HTRANS = S_HSEL ? HTRANS_NONSEQ : HTRANS_IDLE;

  always_comb begin
    S_HADDR  = '0;
    S_HWRITE = 1'b0;
    S_HSIZE  = '0;
    if (grant[1]) begin
      S_HADDR  = req_addr[1];
      S_HWRITE = req_write[1];
      S_HSIZE  = req_size[1];
    end else if (grant[0]) begin
      S_HADDR  = req_addr[0];
      S_HWRITE = req_write[0];
      S_HSIZE  = req_size[0];
    end
  end

  // At most one port owns the data phase, so the priority order here never matters.
  assign S_HWDATA  = in_data[0] ? M0_HWDATA : (in_data[1] ? M1_HWDATA : '0);
  assign M0_HRDATA = in_data[0] ? S_HRDATA : '0;
  assign M1_HRDATA = in_data[1] ? S_HRDATA : '0;
  assign M0_HRESP  = HRESP_OKAY;
  assign M1_HRESP  = HRESP_OKAY;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed corner cases plus a randomized two-master run against a transaction-level
// model and a RAM slave with random wait states.
module tb_ahb_ram_arbiter;
  import ahb_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [1:0]    htrans [2];
  logic [AW-1:0] haddr  [2];
  logic          hwrite [2];
  logic [2:0]    hsize  [2];
  logic [DW-1:0] hwdata [2];
  logic [DW-1:0] hrdata [2];
  logic          hready [2];
  logic [1:0]    hresp  [2];
  logic          s_hsel, s_hwrite;
  logic [1:0]    s_htrans;
  logic [AW-1:0] s_haddr;
  logic [2:0]    s_hsize;
  logic [DW-1:0] s_hwdata, s_hrdata;
  logic          s_hready;

  logic [DW-1:0] fp_hrdata [2];
  logic          fp_hready [2];
  logic [1:0]    fp_hresp  [2];
  logic          fp_s_hsel, fp_s_hwrite;
  logic [1:0]    fp_s_htrans;
  logic [AW-1:0] fp_s_haddr;
  logic [2:0]    fp_s_hsize;
  logic [DW-1:0] fp_s_hwdata;

  always #5 HCLK = ~HCLK;

  ahb_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HTRANS(htrans[0]), .M0_HADDR(haddr[0]), .M0_HWRITE(hwrite[0]), .M0_HSIZE(hsize[0]),
    .M0_HWDATA(hwdata[0]), .M0_HRDATA(hrdata[0]), .M0_HREADY(hready[0]), .M0_HRESP(hresp[0]),
    .M1_HTRANS(htrans[1]), .M1_HADDR(haddr[1]), .M1_HWRITE(hwrite[1]), .M1_HSIZE(hsize[1]),
    .M1_HWDATA(hwdata[1]), .M1_HRDATA(hrdata[1]), .M1_HREADY(hready[1]), .M1_HRESP(hresp[1]),
    .S_HSEL(s_hsel), .S_HTRANS(s_htrans), .S_HADDR(s_haddr), .S_HWRITE(s_hwrite),
    .S_HSIZE(s_hsize), .S_HWDATA(s_hwdata), .S_HRDATA(s_hrdata), .S_HREADY(s_hready)
  );

  ahb_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_fp (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HTRANS(htrans[0]), .M0_HADDR(haddr[0]), .M0_HWRITE(hwrite[0]), .M0_HSIZE(hsize[0]),
    .M0_HWDATA(hwdata[0]), .M0_HRDATA(fp_hrdata[0]), .M0_HREADY(fp_hready[0]), .M0_HRESP(fp_hresp[0]),
    .M1_HTRANS(htrans[1]), .M1_HADDR(haddr[1]), .M1_HWRITE(hwrite[1]), .M1_HSIZE(hsize[1]),
    .M1_HWDATA(hwdata[1]), .M1_HRDATA(fp_hrdata[1]), .M1_HREADY(fp_hready[1]), .M1_HRESP(fp_hresp[1]),
    .S_HSEL(fp_s_hsel), .S_HTRANS(fp_s_htrans), .S_HADDR(fp_s_haddr), .S_HWRITE(fp_s_hwrite),
    .S_HSIZE(fp_s_hsize), .S_HWDATA(fp_s_hwdata), .S_HRDATA(s_hrdata), .S_HREADY(s_hready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    @(negedge HCLK);
  endtask

  task automatic idle_inputs();
    for (int x = 0; x < 2; x++) begin
      htrans[x] = HTRANS_IDLE;
      haddr[x]  = '0;
      hwrite[x] = 1'b0;
      hsize[x]  = 3'b010;
      hwdata[x] = '0;
    end
    s_hready = 1'b1;
    s_hrdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) tick();
  endtask

  // Randomized-phase state: transaction-level view of each master and the slave RAM.
  bit [1:0]      wait_q, issued_q, acc, cand_m, exp_rdy;
  logic [AW-1:0] wait_addr [2];
  logic          wait_write[2];
  logic [2:0]    wait_size [2];
  int            last_m, winner, n_acc, n_slv, mism;
  bit            slot;
  logic          d_valid [2], d_write [2];
  logic [AW-1:0] d_addr  [2];
  logic [DW-1:0] d_wdata [2];
  logic [1:0]    nx_htrans [2];
  logic [AW-1:0] nx_haddr  [2];
  logic          nx_hwrite [2];
  logic [2:0]    nx_hsize  [2];
  logic [DW-1:0] nx_wdata  [2];
  logic          sl_valid, sl_write;
  logic [AW-1:0] sl_addr;
  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] e_addr;
  logic          e_write;
  logic [2:0]    e_size;
  logic [DW-1:0] e_wdata;
  int            hsel_seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Reset state
    settle();
    check("rst m0_hready", hready[0], 1'b1);
    check("rst m1_hready", hready[1], 1'b1);
    check("rst s_hsel", s_hsel, 1'b0);
    check("rst s_htrans", s_htrans, HTRANS_IDLE);
    check("rst s_haddr", s_haddr, '0);
    check("rst m0_hrdata", hrdata[0], '0);
    check("rst s_hwdata", s_hwdata, '0);
    check("rst m1_hresp", hresp[1], HRESP_OKAY);

    // Single M0 read goes straight through
    tick();
    htrans[0] = HTRANS_NONSEQ; haddr[0] = 8'h10;
    settle();
    check("rd s_hsel", s_hsel, 1'b1);
    check("rd s_htrans", s_htrans, HTRANS_NONSEQ);
    check("rd s_haddr", s_haddr, 8'h10);
    check("rd s_hwrite", s_hwrite, 1'b0);
    tick();
    htrans[0] = HTRANS_IDLE; s_hrdata = 32'hDEADBEEF;
    settle();
    check("rd m0_hrdata", hrdata[0], 32'hDEADBEEF);
    check("rd m0_hready", hready[0], 1'b1);
    check("rd m1_hrdata", hrdata[1], '0);
    check("rd s_hsel idle", s_hsel, 1'b0);

    // Tie after reset (M0 wins), then M1 pending beats a fresh M0 request
    apply_reset();
    htrans[0] = HTRANS_NONSEQ; haddr[0] = 8'h04;
    htrans[1] = HTRANS_NONSEQ; haddr[1] = 8'h08;
    settle();
    check("tie1 s_haddr", s_haddr, 8'h04);
    check("tie1 fp s_haddr", fp_s_haddr, 8'h08);
    tick();
    haddr[0] = 8'h0C; htrans[1] = HTRANS_IDLE;
    settle();
    check("tie2 m1_hready", hready[1], 1'b0);
    check("tie2 s_haddr", s_haddr, 8'h08);
    check("tie2 m0_hready", hready[0], 1'b1);
    check("tie2 fp s_haddr", fp_s_haddr, 8'h04);
    check("tie2 fp m0_hready", fp_hready[0], 1'b0);
    tick();
    htrans[0] = HTRANS_IDLE;
    settle();
    check("tie3 s_haddr", s_haddr, 8'h0C);
    check("tie3 m0_hready", hready[0], 1'b0);
    check("tie3 m1_hready", hready[1], 1'b1);
    drain(4);

    // Another fresh tie: M0 was granted last, so RR picks M1; fixed priority picks M1 too
    htrans[0] = HTRANS_NONSEQ; haddr[0] = 8'h14;
    htrans[1] = HTRANS_NONSEQ; haddr[1] = 8'h18;
    settle();
    check("tie4 s_haddr", s_haddr, 8'h18);
    check("tie4 fp s_haddr", fp_s_haddr, 8'h18);
    tick();
    htrans[0] = HTRANS_IDLE; htrans[1] = HTRANS_IDLE;
    settle();
    check("tie5 s_haddr", s_haddr, 8'h14);
    drain(4);

    // M1 write with two slave wait states; an M0 request during the stall must wait
    htrans[1] = HTRANS_NONSEQ; haddr[1] = 8'h20; hwrite[1] = 1'b1;
    settle();
    check("wr s_haddr", s_haddr, 8'h20);
    check("wr s_hwrite", s_hwrite, 1'b1);
    tick();
    htrans[1] = HTRANS_IDLE; hwrite[1] = 1'b0; hwdata[1] = 32'hA5A5A5A5; s_hready = 1'b0;
    htrans[0] = HTRANS_NONSEQ; haddr[0] = 8'h30;
    settle();
    check("stall1 s_hwdata", s_hwdata, 32'hA5A5A5A5);
    check("stall1 m1_hready", hready[1], 1'b0);
    check("stall1 s_hsel", s_hsel, 1'b0);
    check("stall1 m0_hready", hready[0], 1'b1);
    tick();
    htrans[0] = HTRANS_IDLE;
    settle();
    check("stall2 s_hwdata", s_hwdata, 32'hA5A5A5A5);
    check("stall2 m1_hready", hready[1], 1'b0);
    check("stall2 m0_hready", hready[0], 1'b0);
    check("stall2 s_hsel", s_hsel, 1'b0);
    tick();
    s_hready = 1'b1;
    settle();
    check("stall end m1_hready", hready[1], 1'b1);
    check("stall end s_hwdata", s_hwdata, 32'hA5A5A5A5);
    check("stall end s_hsel", s_hsel, 1'b1);
    check("stall end s_haddr", s_haddr, 8'h30);
    drain(4);

    // Reset while M0 is pending abandons its transfer
    htrans[1] = HTRANS_NONSEQ; haddr[1] = 8'h40;
    settle();
    check("rstp s_haddr", s_haddr, 8'h40);
    tick();
    htrans[1] = HTRANS_IDLE; s_hready = 1'b0;
    htrans[0] = HTRANS_NONSEQ; haddr[0] = 8'h50;
    settle();
    check("rstp pend s_hsel", s_hsel, 1'b0);
    tick();
    htrans[0] = HTRANS_IDLE; s_hready = 1'b1; HRESET = 1'b1;
    settle();
    check("rstp during s_hsel", s_hsel, 1'b0);
    tick();
    HRESET = 1'b0;
    settle();
    check("rstp m0_hready", hready[0], 1'b1);
    check("rstp s_hsel", s_hsel, 1'b0);
    hsel_seen = 0;
    repeat (4) begin
      tick();
      settle();
      if (s_hsel) hsel_seen++;
    end
    check("rstp no slave access", hsel_seen, 0);

    // Randomized traffic: M0 uses addresses 0x00-0x0F, M1 uses 0x80-0x8F
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    wait_q = '0; issued_q = '0; last_m = 1; n_acc = 0; n_slv = 0;
    sl_valid = 1'b0; sl_write = 1'b0; sl_addr = '0;
    for (int x = 0; x < 2; x++) begin
      d_valid[x] = 1'b0; d_write[x] = 1'b0; d_addr[x] = '0; d_wdata[x] = '0;
      nx_htrans[x] = HTRANS_IDLE; nx_haddr[x] = '0; nx_hwrite[x] = 1'b0;
      nx_hsize[x] = 3'b010; nx_wdata[x] = '0;
    end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      settle();
      for (int x = 0; x < 2; x++) begin
        exp_rdy[x] = wait_q[x] ? 1'b0 : (issued_q[x] ? s_hready : 1'b1);
        check("hready", hready[x], exp_rdy[x]);
        acc[x]    = htrans[x][1] && exp_rdy[x];
        cand_m[x] = wait_q[x] || acc[x];
        check("hrdata route", hrdata[x], issued_q[x] ? s_hrdata : '0);
        check("hresp", hresp[x], HRESP_OKAY);
      end
      slot = (issued_q == 2'b00) || s_hready;
      winner = -1;
      if (slot) begin
        if (cand_m == 2'b11) winner = 1 - last_m;
        else if (cand_m[0])  winner = 0;
        else if (cand_m[1])  winner = 1;
      end
      check("s_hsel", s_hsel, winner >= 0);
      if (winner >= 0) begin
        e_addr  = wait_q[winner] ? wait_addr[winner]  : haddr[winner];
        e_write = wait_q[winner] ? wait_write[winner] : hwrite[winner];
        e_size  = wait_q[winner] ? wait_size[winner]  : hsize[winner];
        check("s_haddr", s_haddr, e_addr);
        check("s_hwrite", s_hwrite, e_write);
        check("s_hsize", s_hsize, e_size);
        check("s_htrans", s_htrans, HTRANS_NONSEQ);
      end else begin
        check("s_htrans idle", s_htrans, HTRANS_IDLE);
        check("s_haddr idle", s_haddr, '0);
      end
      e_wdata = issued_q[0] ? hwdata[0] : (issued_q[1] ? hwdata[1] : '0);
      check("s_hwdata", s_hwdata, e_wdata);

      // Master-side completions update the golden memory in slave order
      for (int x = 0; x < 2; x++) begin
        if (d_valid[x] && exp_rdy[x]) begin
          if (d_write[x]) ref_mem[d_addr[x]] = d_wdata[x];
          else            check("read data", hrdata[x], ref_mem[d_addr[x]]);
        end
      end

      // RAM slave
      if (sl_valid && s_hready) begin
        if (sl_write) ram[sl_addr] = s_hwdata;
        sl_valid = 1'b0;
      end
      if (s_hsel && s_hready) begin
        sl_valid = 1'b1; sl_addr = s_haddr; sl_write = s_hwrite; n_slv++;
      end

      // Model bookkeeping
      for (int x = 0; x < 2; x++) begin
        if (issued_q[x] && s_hready) issued_q[x] = 1'b0;
        if (acc[x]) begin
          n_acc++;
          if (winner != x) begin
            wait_q[x] = 1'b1; wait_addr[x] = haddr[x];
            wait_write[x] = hwrite[x]; wait_size[x] = hsize[x];
          end
        end
      end
      if (winner >= 0) begin
        issued_q[winner] = 1'b1; wait_q[winner] = 1'b0; last_m = winner;
      end

      // Masters advance only when their HREADY was high
      for (int x = 0; x < 2; x++) begin
        if (exp_rdy[x]) begin
          d_valid[x] = acc[x];
          if (acc[x]) begin
            d_addr[x] = haddr[x]; d_write[x] = hwrite[x]; d_wdata[x] = nx_wdata[x];
          end
          if (cyc < 1960 && $urandom_range(0, 1) == 1) begin
            nx_htrans[x] = HTRANS_NONSEQ;
            nx_haddr[x]  = {x[0], 3'b000, 4'($urandom_range(0, 15))};
            nx_hwrite[x] = 1'($urandom_range(0, 1));
            nx_hsize[x]  = 3'($urandom_range(0, 7));
            nx_wdata[x]  = $urandom;
          end else begin
            nx_htrans[x] = HTRANS_IDLE;
            nx_haddr[x]  = 8'($urandom);
          end
        end
      end

      tick();
      for (int x = 0; x < 2; x++) begin
        htrans[x] = nx_htrans[x];
        haddr[x]  = nx_haddr[x];
        hwrite[x] = nx_hwrite[x];
        hsize[x]  = nx_hsize[x];
        hwdata[x] = (d_valid[x] && d_write[x]) ? d_wdata[x] : $urandom;
      end
      s_hready = sl_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_hrdata = (sl_valid && !sl_write) ? ram[sl_addr] : $urandom;
    end

    check("transfer count", n_slv, n_acc);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("ram image mismatches", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ram_arbiter.md
AHB_RAM_ARBITER -- requirements
Module: ahb_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, address width on master and slave sides.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority (M1 wins).
REQ-004 HCLK  in  1  single clock; all state on rising edge.
REQ-005 HRESET  in  1  reset, synchronous, active-high.
REQ-006 M0_HTRANS, M1_HTRANS  in  2  master transfer type; request = HTRANS[1].
REQ-007 M0_HADDR, M1_HADDR  in  ADDR_W  master address.
REQ-008 M0_HWRITE, M1_HWRITE  in  1  1 = write, 0 = read.
REQ-009 M0_HSIZE, M1_HSIZE  in  3  transfer size, passed through unchanged.
REQ-010 M0_HWDATA, M1_HWDATA  in  DATA_W  write data, valid in the master's data phase.
REQ-011 M0_HRDATA, M1_HRDATA  out  DATA_W  read data to master.
REQ-012 M0_HREADY, M1_HREADY  out  1  per-master ready (address accept / data-phase done).
REQ-013 M0_HRESP, M1_HRESP  out  2  always 2'b00 (OKAY).
REQ-014 S_HSEL, S_HTRANS(2), S_HADDR(ADDR_W), S_HWRITE, S_HSIZE(3)  out  slave address phase.
REQ-015 S_HWDATA  out  DATA_W  slave write data; S_HRDATA  in  DATA_W; S_HREADY  in  1.

Function
REQ-016 Each master port SHALL hold one state: P_IDLE, P_PEND (accepted, awaiting slave slot), P_DATA (owns slave data phase).
REQ-017 Mx_HREADY SHALL be 1 in P_IDLE, 0 in P_PEND, S_HREADY in P_DATA.
REQ-018 Fresh accept SHALL occur when request=1 and Mx_HREADY=1 in the same cycle.
REQ-019 Slave address slot SHALL be free when no port is in P_DATA, or S_HREADY=1.
REQ-020 Slot candidates SHALL be each port's pending entry or its fresh accept; a port never has both.
REQ-021 RR_EN=1: with two candidates, the port not granted most recently SHALL win; RR_EN=0: M1 wins.
REQ-022 Winner SHALL drive S_HSEL=1, S_HTRANS=2'b10, and its address/control (fresh: combinational from master; pending: from buffer); the port enters P_DATA next cycle.
REQ-023 With no winner, S_HSEL=0, S_HTRANS=2'b00, and other S_ address/control outputs SHALL be 0.
REQ-024 A fresh accept that loses or finds no free slot SHALL capture HADDR/HWRITE/HSIZE into the port buffer and enter P_PEND.
REQ-025 P_DATA with S_HREADY=1 SHALL exit to P_DATA (if a new fresh accept wins), P_PEND (if it loses) or P_IDLE (if there is no request).
REQ-026 S_HWDATA SHALL equal the HWDATA of the port in P_DATA; otherwise 0.
REQ-027 Mx_HRDATA SHALL equal S_HRDATA while port x is in P_DATA; otherwise 32'h0.
REQ-028 A directly granted transfer SHALL add zero cycles; a pended transfer SHALL add at least 1 cycle.
REQ-029 S_HREADY=0 SHALL freeze all state; no new slot is granted.
REQ-030 Recording the last-granted port for RR SHALL update only on a grant.

Reset
REQ-031 HRESET=1 SHALL force both ports to P_IDLE, clear buffers, set last-grant=M1 (M0 wins the first tie), S_HSEL=0, S_HTRANS=2'b00, Mx_HREADY=1, Mx_HRDATA=0.
REQ-032 Reset mid-transfer SHALL abandon pending and in-flight transfers with no slave access afterwards.

Structure
REQ-033 Package ahb_arb_pkg SHALL hold the HTRANS codes (IDLE=2'b00, NONSEQ=2'b10), the OKAY code and the port-state enum.
REQ-034 Sub-module ahb_arb_port SHALL implement the per-master state, accept logic and buffer, and SHALL be instantiated twice; arbitration and muxing live at top level.

Verification
REQ-035 Single M0 read, A=8'h10, slave returns 32'hDEADBEEF -> S_HADDR=8'h10 in the accept cycle, M0_HRDATA=32'hDEADBEEF next cycle with M0_HREADY=1.
REQ-036 Simultaneous fresh requests after reset (M0 A=8'h04, M1 A=8'h08) -> M0 issued first; M1 pends with M1_HREADY=0 and is issued next cycle with S_HADDR=8'h08.
REQ-037 Second tie after that -> M1 wins (RR); with RR_EN=0 -> M1 wins both ties.
REQ-038 M1 write 32'hA5A5A5A5 to 8'h20 with S_HREADY=0 for 2 cycles -> S_HWDATA held, state frozen, M1_HREADY=0 until S_HREADY=1.
REQ-039 HRESET asserted while M0 is pending -> next cycle M0_HREADY=1, S_HSEL=0, no transfer to the pended address.
